// File: rtl/qar_irq_ctrl.sv
// Multi-source interrupt controller for the qar_core external IRQ pair.
// Synchronises sources, tracks pending/in-service state, and arbitrates by fixed priority with nesting.
module qar_irq_ctrl #(
  parameter int NUM_SRC     = 8,
  parameter int ID_WIDTH    = 5,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    irq_src,
  output logic                  irq_req,
  output logic [ID_WIDTH-1:0]   irq_id,
  input  logic                  irq_ack,
  output logic [NUM_SRC-1:0]    src_ack,
  input  logic                  cfg_valid,
  input  logic                  cfg_we,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [31:0]           cfg_wdata,
  output logic                  cfg_ready,
  output logic [31:0]           cfg_rdata
);

  localparam logic [ADDR_WIDTH-1:0] A_ENABLE  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_PENDING = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_MODE    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_ACTIVE  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_EOI     = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(5);

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] s, s_q;
  logic [NUM_SRC-1:0] enable, mode, pending, active;
  logic               ack_q;

  logic               cfg_wr, wr_enable, wr_pending, wr_mode, wr_eoi;
  logic               claim;
  logic [NUM_SRC-1:0] claim_mask, eoi_mask, w1c_mask, edge_set;
  logic [NUM_SRC-1:0] pending_next, active_next, enable_next, mode_next;
  logic [NUM_SRC-1:0] elig;
  logic               req_next;
  logic [ID_WIDTH-1:0] id_next;
  logic [31:0]        rd_data;
  logic               unused_wdata;

  assign s      = sync_q[SYNC_STAGES-1];
  assign cfg_wr = cfg_valid & cfg_we;

  assign wr_enable  = cfg_wr && (cfg_addr == A_ENABLE);
  assign wr_pending = cfg_wr && (cfg_addr == A_PENDING);
  assign wr_mode    = cfg_wr && (cfg_addr == A_MODE);
  assign wr_eoi     = cfg_wr && (cfg_addr == A_EOI);

  // Only the registered request the core actually saw can be claimed.
  assign claim = irq_ack & ~ack_q & irq_req;

  assign edge_set     = s & ~s_q;
  assign w1c_mask     = wr_pending ? (cfg_wdata[NUM_SRC-1:0] & mode) : '0;
  assign enable_next  = wr_enable ? cfg_wdata[NUM_SRC-1:0] : enable;
  assign mode_next    = wr_mode ? cfg_wdata[NUM_SRC-1:0] : mode;
  // Set-after-clear ordering gives the edge set priority; level bits just follow s.
  assign pending_next = (mode & ((pending & ~(w1c_mask | claim_mask)) | edge_set)) | (~mode & s);
  // A claim of the same ID overrides a simultaneous EOI.
  assign active_next  = (active & ~eoi_mask) | claim_mask;

  assign unused_wdata = ^cfg_wdata;

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    claim_mask = '0;
    eoi_mask   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_mask[i] = claim && (irq_id == ID_WIDTH'(i));
      eoi_mask[i]   = wr_eoi && (cfg_wdata[ID_WIDTH-1:0] == ID_WIDTH'(i));
    end
  end

  always_comb begin
    logic blocked;
    blocked  = 1'b0;
    elig     = '0;
    req_next = 1'b0;
    id_next  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      blocked = blocked | active_next[i];
      elig[i] = pending[i] & ~w1c_mask[i] & enable_next[i] & ~blocked;
    end
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        req_next = 1'b1;
        id_next  = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (cfg_addr)
      A_ENABLE:  rd_data[NUM_SRC-1:0] = enable;
      A_PENDING: rd_data[NUM_SRC-1:0] = pending;
      A_MODE:    rd_data[NUM_SRC-1:0] = mode;
      A_ACTIVE:  rd_data[NUM_SRC-1:0] = active;
      A_STATUS: begin
        rd_data[31]           = irq_req;
        rd_data[ID_WIDTH-1:0] = irq_id;
      end
      default:   rd_data = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values, in any order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_q       <= '0;
      enable    <= '0;
      mode      <= '0;
      pending   <= '0;
      active    <= '0;
      ack_q     <= 1'b0;
      irq_req   <= 1'b0;
      irq_id    <= '0;
      src_ack   <= '0;
      cfg_ready <= 1'b0;
      cfg_rdata <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_q       <= s;
      enable    <= enable_next;
      mode      <= mode_next;
      pending   <= pending_next;
      active    <= active_next;
      ack_q     <= irq_ack;
      irq_req   <= req_next;
      irq_id    <= id_next;
      src_ack   <= claim_mask;
      cfg_ready <= cfg_valid;
      if (cfg_valid && !cfg_we) cfg_rdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_qar_irq_ctrl.sv
// Self-checking bench for qar_irq_ctrl: claim scoreboard plus register/output checks.
module tb_qar_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq_src;
  logic        irq_req;
  logic [4:0]  irq_id;
  logic        irq_ack;
  logic [7:0]  src_ack;
  logic        cfg_valid, cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_ready;
  logic [31:0] cfg_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  qar_irq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .irq_req(irq_req), .irq_id(irq_id),
    .irq_ack(irq_ack), .src_ack(src_ack), .cfg_valid(cfg_valid), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready), .cfg_rdata(cfg_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
    cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = a;
    tick();
    check({tag, "_ready"}, {31'b0, cfg_ready}, 32'd1);
    check(tag, cfg_rdata, exp);
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_src(input logic [7:0] m);
    irq_src = irq_src | m;
    tick();
    irq_src = irq_src & ~m;
  endtask

  task automatic wait_req(input int id, input string tag);
    int n = 0;
    while (!irq_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, {31'b0, irq_req}, 32'd1);
    check({tag, "_id"}, {27'b0, irq_id}, id);
  endtask

  task automatic claim(input int id);
    exp_q.push_back(id);
    irq_ack = 1'b1;
    tick();
    check("claim_src_ack", {24'b0, src_ack}, 32'd1 << id);
    irq_ack = 1'b0;
    tick();
    check("claim_src_ack_end", {24'b0, src_ack}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Claim scoreboard: every src_ack pulse must match the next expected claim ID.
  always @(negedge clk) begin
    if (rst_n && src_ack !== 8'd0) begin
      if (exp_q.size() == 0) check("unexpected_src_ack", {24'b0, src_ack}, 32'd0);
      else check("sb_claim_order", {24'b0, src_ack}, 32'd1 << exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; irq_src = '0; irq_ack = 1'b0;
    cfg_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    #23;
    check("rst_irq_req", {31'b0, irq_req}, 32'd0);
    check("rst_irq_id", {27'b0, irq_id}, 32'd0);
    check("rst_src_ack", {24'b0, src_ack}, 32'd0);
    check("rst_cfg_ready", {31'b0, cfg_ready}, 32'd0);
    check("rst_cfg_rdata", cfg_rdata, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Edge mode, single source, exact latency.
    cfg_write(3'd0, 32'h20);
    cfg_write(3'd2, 32'h20);
    irq_src[5] = 1'b1;
    tick();
    irq_src[5] = 1'b0;
    idle(2);
    check("lat_edge3_req", {31'b0, irq_req}, 32'd0);
    tick();
    check("lat_edge4_req", {31'b0, irq_req}, 32'd1);
    check("lat_edge4_id", {27'b0, irq_id}, 32'd5);
    claim(5);
    check("t1_req_after_claim", {31'b0, irq_req}, 32'd0);
    cfg_read(3'd1, 32'h00, "t1_pending");
    cfg_read(3'd3, 32'h20, "t1_active");
    cfg_read(3'd5, 32'h00, "t1_status");
    cfg_write(3'd4, 32'd5);
    cfg_read(3'd3, 32'h00, "t1_active_eoi");

    // Fixed priority.
    cfg_write(3'd0, 32'hFF);
    cfg_write(3'd2, 32'hFF);
    pulse_src(8'h44);
    wait_req(2, "t2_first");
    cfg_read(3'd5, 32'h8000_0002, "t2_status");
    claim(2);
    idle(3);
    check("t2_blocked_req", {31'b0, irq_req}, 32'd0);
    cfg_read(3'd3, 32'h04, "t2_active");
    cfg_read(3'd1, 32'h40, "t2_pending");
    cfg_write(3'd4, 32'd2);
    wait_req(6, "t2_second");
    claim(6);
    cfg_write(3'd4, 32'd6);

    // Nesting: 4, then 1 preempts, 7 waits for both EOIs.
    pulse_src(8'h10);
    wait_req(4, "t3_src4");
    claim(4);
    pulse_src(8'h02);
    wait_req(1, "t3_src1");
    claim(1);
    cfg_read(3'd3, 32'h12, "t3_active");
    pulse_src(8'h80);
    idle(6);
    check("t3_src7_held", {31'b0, irq_req}, 32'd0);
    cfg_write(3'd4, 32'd1);
    idle(2);
    check("t3_src7_held_eoi1", {31'b0, irq_req}, 32'd0);
    cfg_write(3'd4, 32'd9);
    cfg_read(3'd3, 32'h10, "t3_active_bad_eoi");
    cfg_write(3'd4, 32'd4);
    wait_req(7, "t3_src7");
    claim(7);
    cfg_write(3'd4, 32'd7);

    // Level mode, source 3 held high.
    cfg_write(3'd2, 32'h00);
    irq_src[3] = 1'b1;
    wait_req(3, "t4_level");
    claim(3);
    idle(2);
    check("t4_req_in_service", {31'b0, irq_req}, 32'd0);
    cfg_write(3'd1, 32'h08);
    cfg_read(3'd1, 32'h08, "t4_w1c_ignored");
    cfg_write(3'd4, 32'd3);
    wait_req(3, "t4_rerequest");
    irq_src[3] = 1'b0;
    idle(6);
    check("t4_req_released", {31'b0, irq_req}, 32'd0);

    // Spurious and held acknowledge.
    cfg_write(3'd2, 32'hFF);
    irq_ack = 1'b1;
    tick();
    check("t5_spurious_src_ack", {24'b0, src_ack}, 32'd0);
    pulse_src(8'h01);
    wait_req(0, "t5_held");
    idle(3);
    check("t5_held_no_claim", {24'b0, src_ack}, 32'd0);
    cfg_read(3'd3, 32'h00, "t5_active_held");
    irq_ack = 1'b0;
    tick();
    claim(0);
    cfg_write(3'd4, 32'd0);

    // Asynchronous reset in the src_ack cycle.
    pulse_src(8'h20);
    wait_req(5, "t6_req");
    irq_ack = 1'b1;
    tick();
    check("t6_src_ack_before_rst", {24'b0, src_ack}, 32'h20);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_src_ack", {24'b0, src_ack}, 32'd0);
    check("t6_rst_irq_req", {31'b0, irq_req}, 32'd0);
    check("t6_rst_irq_id", {27'b0, irq_id}, 32'd0);
    check("t6_rst_cfg_ready", {31'b0, cfg_ready}, 32'd0);
    check("t6_rst_cfg_rdata", cfg_rdata, 32'd0);
    irq_ack = 1'b0;
    #4 rst_n = 1'b1;
    tick();
    for (int a = 0; a < 6; a++) cfg_read(3'(a), 32'd0, "t6_reg_after_rst");

    idle(2);
    check("sb_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qar_irq_ctrl.md
Name: qar_irq_ctrl

Overview:
- Parametrised interrupt controller between N peripheral interrupt sources and the qar_core `irq_external`/`irq_external_ack` pair.
- Generalises the single external-IRQ line and ack handshake to NUM_SRC channels.
- Per-channel features: synchronisation, edge/level mode, enable mask, pending/in-service tracking, fixed-priority selection with nesting, EOI completion.
- Software configures it through a word-addressed register port driven from the core's data bus decode.

Parameters:
- NUM_SRC, 8: number of interrupt sources, 1..32.
- ID_WIDTH, 5: width of the source-ID fields; must satisfy 2^ID_WIDTH >= NUM_SRC.
- SYNC_STAGES, 2: synchroniser flops per source, >= 2.
- ADDR_WIDTH, 3: word-index width of the register port.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq_src  in  NUM_SRC  raw asynchronous interrupt sources.
- irq_req  out  1  registered request to core `irq_external`.
- irq_id  out  ID_WIDTH  ID of the current winning source; valid while irq_req=1.
- irq_ack  in  1  core `irq_external_ack`; a rising edge claims the winner.
- src_ack  out  NUM_SRC  one-cycle claim pulse per source.
- cfg_valid  in  1  register access request.
- cfg_we  in  1  1 = write, 0 = read.
- cfg_addr  in  ADDR_WIDTH  word index.
- cfg_wdata  in  32  write data.
- cfg_ready  out  1  access completes.
- cfg_rdata  out  32  read data, valid with cfg_ready.

Behaviour:
- Reset (async assert, sync release). All of the following clear to 0: sync chains, enable, mode, pending, active, irq_req, irq_id, src_ack, cfg_ready, cfg_rdata, ack-edge register.
- Sync and edge detect:
  - irq_src[i] passes through SYNC_STAGES flops, giving s[i].
  - An s_q[i] register provides edge detection.
- Pending, edge mode (mode[i]=1):
  - pending[i] is set on s[i] & ~s_q[i].
  - Cleared by a W1C write or by a claim.
  - A set and a clear in the same cycle: set wins.
- Pending, level mode (mode[i]=0):
  - pending[i] = s[i] each cycle; W1C has no effect.
  - A claim does not clear it; a masked re-request is prevented by active[i].
- Eligibility: elig[i] = pending[i] & enable[i] & ~active[i] & (i < lowest set index of active). Lower index = higher priority; an empty active set admits all.
- Winner is the lowest eligible index.
- irq_req and irq_id are registered from next-state eligibility. Latency from irq_src high before edge 1: s at edge SYNC_STAGES, pending at SYNC_STAGES+1, irq_req at SYNC_STAGES+2.
- Claim on the irq_ack rising edge (irq_ack & ~ack_q), evaluated against current registered state:
  - The winner's active bit is set.
  - Its src_ack bit is asserted for exactly the next cycle.
  - Edge pending is cleared.
  - irq_req deasserts the following cycle unless another source is eligible (only one with higher priority can be, because of nesting).
  - A claim with no eligible source is ignored: no src_ack, no state change.
  - A held irq_ack high does not re-claim.
- Completion: an EOI write clears active[wdata[ID_WIDTH-1:0]]. IDs >= NUM_SRC are ignored. A lower-priority pending source may then re-request.
- Register port:
  - cfg_ready is asserted exactly one cycle after any cfg_valid cycle (registered, 1-cycle latency); back-to-back accesses are allowed.
  - Reads are registered into cfg_rdata.
  - Unused bits read 0; undefined addresses read 0 and ignore writes.
- Register map (word index):
  - 0 ENABLE: RW.
  - 1 PENDING: R; W1C for edge-mode bits.
  - 2 MODE: RW, 1 = edge.
  - 3 ACTIVE: R.
  - 4 EOI: W.
  - 5 STATUS: R; {irq_req, 23'b0, 3'b0, irq_id} with irq_id in the low ID_WIDTH bits.
- Config write vs claim in the same cycle: both take effect. An EOI for index j and a claim of j in the same cycle: the claim wins (active stays 1).
- Disabling a source with a request outstanding: irq_req drops on the next registered update; pending is retained.
- Reset mid-operation: all state clears immediately and asynchronously; src_ack never extends past reset assertion.

Test Plan:
- Edge mode, source 5: ENABLE=0x20, MODE=0x20; pulse irq_src[5] for 1 cycle -> irq_req=1, irq_id=5 at edge 4; irq_ack rise -> src_ack[5] one-cycle pulse, PENDING=0, ACTIVE=0x20, irq_req=0; EOI=5 -> ACTIVE=0.
- Priority: ENABLE=0xFF, all edge; raise src 6 and src 2 in the same cycle -> irq_id=2; claim; irq_req stays 0 while ACTIVE=0x04; EOI=2 -> irq_req=1, irq_id=6.
- Nesting: claim src 4, then raise src 1 -> irq_id=1 and a second claim succeeds, ACTIVE=0x12; raise src 7 -> no request until both EOIs are done. Log order of claims is 4, 1, 7.
- Level mode: src 3 held high; claim, then EOI while still high -> irq_req reasserts with irq_id=3. A W1C write of 0x08 leaves PENDING[3]=1.
- Spurious/held ack: irq_ack rise with nothing pending -> no src_ack, state unchanged; irq_ack held high across a new request -> no claim until the next rising edge.
- Reset mid-claim: assert rst_n=0 in the src_ack cycle -> all outputs 0 asynchronously; after release, reads of registers 0-5 return 0.
